// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit frame controller in front of the TX serializer.
// Revision : 1.0
// ============================================================================
module uart_tx_ctrl #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic       data_ready,
  output logic [7:0] ser_data,
  output logic       ser_en,
  input  logic       ser_done,
  input  logic       ser_bit,
  output logic       tx_out,
  output logic       busy,
  output logic       sync_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Any value other than 2 falls back to a single stop bit.
  localparam logic c_LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t     r_state;
  logic [7:0] r_hold;
  logic [2:0] r_bit_cnt;
  logic       r_stop_cnt;
  logic       r_par;
  logic       r_pen;
  logic       r_sync_err;

  logic       w_last_stop;
  logic       w_ready;
  logic       w_accept;
  logic       w_bit_last;
  logic       w_sync_miss;

  assign w_last_stop = (r_state == S_STOP) && (r_stop_cnt == c_LAST_STOP);
  assign w_ready     = (r_state == S_IDLE) || w_last_stop;
  assign w_accept    = data_valid && w_ready;
  assign w_bit_last  = (r_bit_cnt == 3'd7);
  // The serializer must flag done on the 8th shift cycle and on no other.
  assign w_sync_miss = (ser_done != w_bit_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_hold     <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_pen      <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= data_in;
        r_par  <= (^data_in) ^ parity_type;
        r_pen  <= parity_en;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_START;
        end
        S_START: begin
          r_bit_cnt <= 3'd0;
          r_state   <= S_DATA;
        end
        S_DATA: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_sync_miss) r_sync_err <= 1'b1;
          if (w_bit_last) begin
            r_stop_cnt <= 1'b0;
            r_state    <= r_pen ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          r_stop_cnt <= 1'b0;
          r_state    <= S_STOP;
        end
        S_STOP: begin
          if (w_last_stop) begin
            r_state <= w_accept ? S_START : S_IDLE;
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_out = 1'b1;
    case (r_state)
      S_START:  tx_out = 1'b0;
      S_DATA:   tx_out = ser_bit;
      S_PARITY: tx_out = r_par;
      default:  tx_out = 1'b1;
    endcase
  end

  assign data_ready = w_ready;
  assign busy       = (r_state != S_IDLE);
  assign ser_en     = (r_state == S_DATA);
  assign ser_data   = r_hold;
  assign sync_err   = r_sync_err;

endmodule
`default_nettype wire
